dmem_arbiter: RTL

- Arbitrates a single-port data memory between two requesters: the CPU load/store path and a DMA/debug port.
- Sits between the memory stage and the data RAM.
- Sequences each access through a fixed-latency protocol and stalls the CPU while its access is pending or blocked.
- Round-robin arbitration prevents either side from starving the other.

---
 rtl/dmem_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one single-port data RAM between the CPU and DMA/debug ports.
// Latency: grant in the request cycle when IDLE; rvalid MEM_LATENCY+1 cycles after the grant.
// Backpressure: a requester waits (CPU stalled) until the FSM is IDLE and it wins arbitration. Optional DMEM_ARB_PERF_EN adds perf counters.
module dmem_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_gnt,
  output logic                  dma_rvalid,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic [31:0]           perf_cpu_wait,
  output logic [31:0]           perf_dma_grants
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  // WAIT lasts MEM_LATENCY cycles; the counter hits zero in the cycle the RAM data is valid.
  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_e                state_q, state_d;
  logic                  last_dma_q, last_dma_d;  // 1: DMA won the most recent contended grant
  logic                  win_dma_q, win_dma_d;    // owner of the access in flight
  logic                  we_q, we_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_WIDTH-1:0] dma_rdata_q, dma_rdata_d;
  logic                  pick_dma;

  // Next-state, arbitration and strobe generation. Grants are held off while rst is low so
  // every output reads zero during reset even if requests are asserted.
  always_comb begin
    state_d     = state_q;
    last_dma_d  = last_dma_q;
    win_dma_d   = win_dma_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    pick_dma    = 1'b0;
    cpu_gnt     = 1'b0;
    dma_gnt     = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    cpu_rvalid  = 1'b0;
    dma_rvalid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rst && (cpu_req || dma_req)) begin
          // Round-robin pointer only moves on contention; a lone requester is simply served.
          if (cpu_req && dma_req) begin
            pick_dma   = ~last_dma_q;
            last_dma_d = ~last_dma_q;
          end else begin
            pick_dma = dma_req;
          end
          cpu_gnt   = ~pick_dma;
          dma_gnt   = pick_dma;
          mem_en    = 1'b1;
          mem_we    = pick_dma ? dma_we    : cpu_we;
          mem_addr  = pick_dma ? dma_addr  : cpu_addr;
          mem_wdata = pick_dma ? dma_wdata : cpu_wdata;
          win_dma_d = pick_dma;
          we_d      = mem_we;
          cnt_d     = CNT_INIT;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          // Writes complete with rvalid but leave the requester's read data untouched.
          if (!we_q) begin
            if (win_dma_q) dma_rdata_d = mem_rdata;
            else           cpu_rdata_d = mem_rdata;
          end
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        cpu_rvalid = ~win_dma_q;
        dma_rvalid = win_dma_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and data registers; reset drops any in-flight access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      last_dma_q  <= 1'b1;
      win_dma_q   <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= 4'd0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_dma_q  <= last_dma_d;
      win_dma_q   <= win_dma_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign cpu_stall = rst & cpu_req & ~cpu_rvalid;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_cpu_wait_q, perf_cpu_wait_d;
  logic [31:0] perf_dma_grants_q, perf_dma_grants_d;

  // Saturating event counters.
  always_comb begin
    perf_cpu_wait_d   = perf_cpu_wait_q;
    perf_dma_grants_d = perf_dma_grants_q;
    if (cpu_stall && (perf_cpu_wait_q != 32'hFFFF_FFFF))
      perf_cpu_wait_d = perf_cpu_wait_q + 32'd1;
    if (dma_gnt && (perf_dma_grants_q != 32'hFFFF_FFFF))
      perf_dma_grants_d = perf_dma_grants_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cpu_wait_q   <= 32'd0;
      perf_dma_grants_q <= 32'd0;
    end else begin
      perf_cpu_wait_q   <= perf_cpu_wait_d;
      perf_dma_grants_q <= perf_dma_grants_d;
    end
  end

  assign perf_cpu_wait   = perf_cpu_wait_q;
  assign perf_dma_grants = perf_dma_grants_q;
`else
  assign perf_cpu_wait   = 32'd0;
  assign perf_dma_grants = 32'd0;
`endif

endmodule
